digit_serial_adder: RTL

Parametrised, multi-cycle adder/subtractor for the CPU datapath. It processes WIDTH-bit operands DIGIT bits per clock under a start/done handshake, trading latency for a narrow carry chain. It produces the sum together with carry, signed-overflow and zero flags, and holds the result until the next operation. It is the sequential successor to the single-cycle ALU-based adder, for use in the multi-cycle datapath and the future multiply/divide unit.

---
 rtl/digit_serial_adder.sv | 124 ++++++++++++
 1 files changed

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit add/sub, DIGIT bits per clock, with carry/overflow/zero flags.
// Latency: N = WIDTH/DIGIT clocks from the accepting edge to done_o; results are held until the next done.
// Backpressure: none; start_i is taken only in IDLE or DONE and is dropped (never queued) while busy.
//
// Ports:
//   clk_i, rst_i (sync, active-low)           clock and reset
//   start_i, sub_i, src1_i, src2_i            operation request and operands, sampled on accept
//   busy_o, done_o                            RUN indicator, one-cycle completion pulse
//   sum_o, carry_o, overflow_o, zero_o        registered result and flags
module digit_serial_adder #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o,
  output logic             zero_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // already inverted for subtract
  logic [WIDTH-1:0] r_part;   // partial result, filled from the top down
  logic             r_c;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_dsum;
  logic             w_cin_msb;
  logic [WIDTH-1:0] w_part_nxt;

  assign w_accept = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CW'(N - 1));

  // One digit of the ripple: low DIGIT bits of each operand plus the running carry.
  assign w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};

  // On the last digit the top bit of the digit is the word MSB, so the carry into
  // it is recovered from the sum bit and the two operand bits.
  assign w_cin_msb = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

  // After N shifts the first digit has moved down to bit 0, giving the full word.
  assign w_part_nxt = (r_part >> DIGIT) | (WIDTH'(w_dsum[DIGIT-1:0]) << (WIDTH - DIGIT));

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        busy_o = 1'b1;
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o      = 1'b1;
        w_state_nxt = start_i ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_cnt      <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= 1'b0;
      r_part     <= '0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      zero_o     <= 1'b0;
    end else if (w_accept) begin
      r_a   <= src1_i;
      r_b   <= sub_i ? ~src2_i : src2_i;
      r_c   <= sub_i;   // +1 completes the two's complement of B
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a    <= r_a >> DIGIT;
      r_b    <= r_b >> DIGIT;
      r_c    <= w_dsum[DIGIT];
      r_part <= w_part_nxt;
      r_cnt  <= r_cnt + CW'(1);
      if (w_last) begin
        sum_o      <= w_part_nxt;
        carry_o    <= w_dsum[DIGIT];
        overflow_o <= w_cin_msb ^ w_dsum[DIGIT];
        zero_o     <= (w_part_nxt == '0);
      end
    end
  end

endmodule
